// File: rtl/count_check_pkg.sv
// Shared types and helpers for the count sequence checker.
// Holds the checker FSM state encoding and the wrap-around increment.
package count_check_pkg;

    typedef enum logic {SYNC, TRACK} state_t;

    // Increment a value of the given width and discard the carry out of that width
    function automatic logic [31:0] incWrap(input logic [31:0] value, input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// The counter sticks at all-ones once reached.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (inc && (value_q != {W{1'b1}})) begin
            value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Monitors a free-running counter bus, locks onto its sequence and
// flags any enabled sample that is not the previous sample plus one.
module count_sequence_checker
    import count_check_pkg::*;
#(
    parameter int N      = 4,
    parameter int LOCK_N = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [N-1:0]     cnt_in,
    output logic             locked,
    output logic             error,
    output logic [N-1:0]     expected,
    output logic [ERR_W-1:0] err_count
);

    localparam int RUN_W = $clog2(LOCK_N + 1);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_N);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             seeded_q, seeded_d;
    logic [N-1:0]     expected_q, expected_d;
    logic             locked_q, locked_d;
    logic             error_q, error_d;

    logic             sampleHit;
    logic [RUN_W-1:0] runNext;

    function automatic logic [N-1:0] nextCount(input logic [N-1:0] v);
        return N'(incWrap(32'(v), N));
    endfunction

    // Before the first seed nothing can match, so even cnt_in == 0 seeds
    assign sampleHit = seeded_q && (cnt_in == expected_q);
    assign runNext   = sampleHit ? ((run_q == RUN_LOCK) ? run_q : run_q + RUN_ONE) : RUN_ONE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= SYNC;
            run_q      <= '0;
            seeded_q   <= 1'b0;
            expected_q <= '0;
            locked_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            seeded_q   <= seeded_d;
            expected_q <= expected_d;
            locked_q   <= locked_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (enable) begin
            unique case (state_q)
                SYNC:  if (runNext == RUN_LOCK) state_d = TRACK;
                TRACK: if (!sampleHit)          state_d = SYNC;
            endcase
        end
    end

    // A break in TRACK reseeds on the same edge, so the breaking sample starts the next run
    always_comb begin
        run_d      = run_q;
        seeded_d   = seeded_q;
        expected_d = expected_q;
        locked_d   = locked_q;
        error_d    = 1'b0;
        if (enable) begin
            unique case (state_q)
                SYNC: begin
                    expected_d = sampleHit ? nextCount(expected_q) : nextCount(cnt_in);
                    run_d      = runNext;
                    seeded_d   = 1'b1;
                    if (runNext == RUN_LOCK) begin
                        locked_d = 1'b1;
                    end
                end
                TRACK: begin
                    if (sampleHit) begin
                        expected_d = nextCount(expected_q);
                    end else begin
                        error_d    = 1'b1;
                        locked_d   = 1'b0;
                        expected_d = nextCount(cnt_in);
                        run_d      = RUN_ONE;
                    end
                end
            endcase
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_errCount (
        .clock(clock),
        .reset(reset),
        .inc  (error_d),
        .value(err_count)
    );

    assign locked   = locked_q;
    assign error    = error_q;
    assign expected = expected_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Self-checking bench for count_sequence_checker with a reference model and
// a scoreboard of expected outputs, plus directed checks at key points.
module tb_count_sequence_checker;

    localparam int N      = 4;
    localparam int LOCK_N = 2;
    localparam int ERR_W  = 2;
    localparam int MOD    = 1 << N;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clock;
    logic             reset;
    logic             enable;
    logic [N-1:0]     cntIn;
    logic             locked;
    logic             error;
    logic [N-1:0]     expected;
    logic [ERR_W-1:0] errCount;

    typedef struct packed {
        logic             locked;
        logic             error;
        logic [N-1:0]     expected;
        logic [ERR_W-1:0] errCount;
    } expect_t;

    expect_t scoreboard[$];

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state
    bit mTrack;
    bit mSeeded;
    bit mLocked;
    bit mError;
    int mExp;
    int mRun;
    int mErrCnt;

    count_sequence_checker #(
        .N     (N),
        .LOCK_N(LOCK_N),
        .ERR_W (ERR_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .cnt_in   (cntIn),
        .locked   (locked),
        .error    (error),
        .expected (expected),
        .err_count(errCount)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] required);
        testsRun++;
        if (actual !== required) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, required);
        end
    endtask

    function automatic void resetModel();
        mTrack  = 1'b0;
        mSeeded = 1'b0;
        mLocked = 1'b0;
        mError  = 1'b0;
        mExp    = 0;
        mRun    = 0;
        mErrCnt = 0;
    endfunction

    function automatic void stepModel(input bit en, input int val);
        bit hit;
        mError = 1'b0;
        if (en) begin
            hit = mSeeded && (val == mExp);
            if (mTrack) begin
                if (hit) begin
                    mExp = (mExp + 1) % MOD;
                end else begin
                    mError  = 1'b1;
                    mLocked = 1'b0;
                    mTrack  = 1'b0;
                    mErrCnt = (mErrCnt < ERR_MAX) ? mErrCnt + 1 : ERR_MAX;
                    mExp    = (val + 1) % MOD;
                    mRun    = 1;
                end
            end else begin
                if (hit) begin
                    mExp = (mExp + 1) % MOD;
                    mRun = (mRun < LOCK_N) ? mRun + 1 : LOCK_N;
                end else begin
                    mExp    = (val + 1) % MOD;
                    mRun    = 1;
                    mSeeded = 1'b1;
                end
                if (mRun == LOCK_N) begin
                    mTrack  = 1'b1;
                    mLocked = 1'b1;
                end
            end
        end
    endfunction

    task automatic applyStimulus(input bit en, input int val);
        expect_t e;
        expect_t got;
        @(negedge clock);
        enable = en;
        cntIn  = N'(val);
        stepModel(en, val);
        e.locked   = mLocked;
        e.error    = mError;
        e.expected = N'(mExp);
        e.errCount = ERR_W'(mErrCnt);
        scoreboard.push_back(e);
        @(posedge clock);
        #1;
        got = scoreboard.pop_front();
        checkOutput("sb.locked",   32'(locked),   32'(got.locked));
        checkOutput("sb.error",    32'(error),    32'(got.error));
        checkOutput("sb.expected", 32'(expected), 32'(got.expected));
        checkOutput("sb.errCount", 32'(errCount), 32'(got.errCount));
    endtask

    task automatic resetDut();
        @(negedge clock);
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetModel();
        checkOutput("reset.locked",   32'(locked),   0);
        checkOutput("reset.error",    32'(error),    0);
        checkOutput("reset.expected", 32'(expected), 0);
        checkOutput("reset.errCount", 32'(errCount), 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int v;
        int src;
        int r;
        reset  = 1'b0;
        enable = 1'b0;
        cntIn  = '0;
        resetModel();

        resetDut();

        // Lock acquisition
        applyStimulus(1, 5);
        checkOutput("lock.exp6", 32'(expected), 6);
        checkOutput("lock.unlocked", 32'(locked), 0);
        applyStimulus(1, 6);
        checkOutput("lock.locked", 32'(locked), 1);
        checkOutput("lock.exp7", 32'(expected), 7);
        applyStimulus(1, 7);
        checkOutput("lock.exp8", 32'(expected), 8);
        checkOutput("lock.noerr", 32'(error), 0);

        // Wrap-around
        for (int i = 8; i <= 13; i++) applyStimulus(1, i);
        applyStimulus(1, 14);
        applyStimulus(1, 15);
        applyStimulus(1, 0);
        checkOutput("wrap.noerr", 32'(error), 0);
        applyStimulus(1, 1);
        checkOutput("wrap.locked", 32'(locked), 1);
        checkOutput("wrap.exp2", 32'(expected), 2);

        // Skip detection
        for (int i = 2; i <= 8; i++) applyStimulus(1, i);
        checkOutput("skip.pre", 32'(expected), 9);
        applyStimulus(1, 11);
        checkOutput("skip.error", 32'(error), 1);
        checkOutput("skip.errCount", 32'(errCount), 1);
        checkOutput("skip.unlocked", 32'(locked), 0);
        checkOutput("skip.exp12", 32'(expected), 12);
        applyStimulus(1, 12);
        checkOutput("relock.locked", 32'(locked), 1);
        checkOutput("relock.exp13", 32'(expected), 13);
        checkOutput("relock.noerr", 32'(error), 0);

        // Enable gating
        for (int i = 13; i <= 15; i++) applyStimulus(1, i);
        for (int i = 0; i <= 2; i++) applyStimulus(1, i);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 9);
            checkOutput("gate.exp3", 32'(expected), 3);
            checkOutput("gate.noerr", 32'(error), 0);
        end
        applyStimulus(1, 3);
        checkOutput("gate.exp4", 32'(expected), 4);

        // Asynchronous reset between edges while locked
        #2;
        reset = 1'b1;
        #1;
        resetModel();
        checkOutput("async.locked",   32'(locked),   0);
        checkOutput("async.expected", 32'(expected), 0);
        checkOutput("async.errCount", 32'(errCount), 0);
        @(negedge clock);
        reset = 1'b0;

        // Error tally saturation
        v = 0;
        applyStimulus(1, v);
        for (int k = 1; k <= 5; k++) begin
            v = (v + 1) % MOD;
            applyStimulus(1, v);
            checkOutput("sat.locked", 32'(locked), 1);
            v = (v + 2) % MOD;
            applyStimulus(1, v);
            checkOutput("sat.error", 32'(error), 1);
            checkOutput("sat.errCount", 32'(errCount), (k < 3) ? k : 3);
        end

        // Randomised stream with occasional skips and idle cycles
        resetDut();
        src = $urandom_range(0, MOD - 1);
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                applyStimulus(0, $urandom_range(0, MOD - 1));
            end else begin
                if (r == 1) src = $urandom_range(0, MOD - 1);
                applyStimulus(1, src);
                src = (src + 1) % MOD;
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
